ex_div_unit: RTL and testbench

Iterative 32-bit integer divider in the execute stage, directly downstream of the ID/EX pipeline register. It serves DIV and DIVU, taking operands already resolved through forwarding. It drives the divide stall that freezes the ID/EX register and earlier stages while it runs. It returns quotient (to LO) and remainder (to HI) with a one-cycle valid pulse for the EX/MEM HI/LO write path.

---
 rtl/ex_defs.sv | 17 +
 rtl/div_step.sv | 23 ++
 rtl/ex_div_unit.sv | 153 +++++++++++++++
 tb/tb_ex_div_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_defs.sv
// Shared definitions for the execute-stage divider: widths, FSM states, ALU op codes.
package ex_defs;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = 6;

  // ALU op codes (funct field) that select the divider
  localparam logic [5:0] ALU_OP_DIV  = 6'h1A;
  localparam logic [5:0] ALU_OP_DIVU = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_msb_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // Partial remainder stays below the divisor, so one extra bit holds the trial sign.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    trial   = shifted - {1'b0, dvs_i};
    q_bit_o = ~trial[DATA_W];
    rem_o   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative 32-bit DIV/DIVU unit: one restoring step per cycle, stalls upstream while busy.
module ex_div_unit
  import ex_defs::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned CNT_W  = DIV_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              flush,
  output logic              div_stall,
  output logic              res_valid,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  div_state_e        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DATA_W-1:0] rem_q,       rem_d;
  logic [DATA_W-1:0] dvd_q,       dvd_d;
  logic [DATA_W-1:0] dvs_q,       dvs_d;
  logic [DATA_W-1:0] raw_dvd_q,   raw_dvd_d;
  logic              q_neg_q,     q_neg_d;
  logic              r_neg_q,     r_neg_d;
  logic              dvs_zero_q,  dvs_zero_d;
  logic [DATA_W-1:0] quotient_q,  quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic              res_valid_q, res_valid_d;

  logic [DATA_W-1:0] step_rem;
  logic              step_q_bit;
  logic [DATA_W-1:0] final_q;
  logic              dvd_neg;
  logic              dvs_neg;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[DATA_W-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  assign dvd_neg = div_signed & dividend[DATA_W-1];
  assign dvs_neg = div_signed & divisor[DATA_W-1];
  assign final_q = {dvd_q[DATA_W-2:0], step_q_bit};

  // Stall covers the accepting cycle and every CALC cycle; flush and reset release it at once.
  assign div_stall = ~reset & ~flush &
                     (((state_q == ST_IDLE) & div_start) | (state_q == ST_CALC));

  assign res_valid = res_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  // Next-state, datapath and result logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    raw_dvd_d   = raw_dvd_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dvs_zero_d  = dvs_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          dvd_d      = dvd_neg ? DATA_W'(DATA_W'(0) - dividend) : dividend;
          dvs_d      = dvs_neg ? DATA_W'(DATA_W'(0) - divisor) : divisor;
          raw_dvd_d  = dividend;
          q_neg_d    = dvd_neg ^ dvs_neg;
          r_neg_d    = dvd_neg;
          dvs_zero_d = (divisor == '0);
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        dvd_d = final_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          if (dvs_zero_q) begin
            quotient_d  = '1;
            remainder_d = raw_dvd_q;
          end else begin
            quotient_d  = q_neg_q ? DATA_W'(DATA_W'(0) - final_q) : final_q;
            remainder_d = r_neg_q ? DATA_W'(DATA_W'(0) - step_rem) : step_rem;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush kills the operation outright and leaves the visible results untouched.
    if (flush) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      raw_dvd_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dvs_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      raw_dvd_q   <= raw_dvd_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dvs_zero_q  <= dvs_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed table, flush/reset sequences, random vs. model.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        div_stall;
  logic        res_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_valid_cyc = 0;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sgn;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs [9];

  ex_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .div_start  (div_start),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .div_stall  (div_stall),
    .res_valid  (res_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // One divide: start in cycle T, expect stall T..T+32 and res_valid in T+33.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, output logic [31:0] q, output logic [31:0] r);
    int  lat;
    int  gaps;
    bit  seen;
    logic stall_done;
    @(posedge clk); #1;
    reset = 0; flush = 0;
    div_start = 1; div_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    chk({tag, "_stall_T"}, 32'(div_stall), 32'd1);
    chk({tag, "_valid_T"}, 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    div_start = 0; dividend = $urandom; divisor = $urandom; div_signed = $urandom_range(0, 1);
    seen = 0; lat = 0; gaps = 0; stall_done = 1'b1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1; lat = c; stall_done = div_stall; last_valid_cyc = cyc;
      end else if (!div_stall) begin
        gaps++;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_stall_gaps"}, 32'(gaps), 32'd0);
    chk({tag, "_stall_done"}, 32'(stall_done), 32'd0);
    q = quotient;
    r = remainder;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      div_start = 0; flush = 0; reset = 0;
    end
  endtask

  initial begin
    logic [31:0] q, r, eq, er, a, b;
    logic        s;
    int          first_valid;
    int          pulses;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678};
    vecs[4] = '{32'h8000_0000,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0000};
    vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vecs[6] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    vecs[7] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF};
    vecs[8] = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5};

    // Reset state, with a start request that must not raise the stall.
    reset = 1; flush = 0; div_start = 1; div_signed = 0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_stall", 32'(div_stall), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_quot",  quotient,  32'd0);
    chk("rst_rem",   remainder, 32'd0);
    idle_cycles(2);
    @(negedge clk);
    chk("post_rst_stall", 32'(div_stall), 32'd0);

    // Directed table.
    foreach (vecs[i]) begin
      run_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, q, r);
      chk($sformatf("vec%0d_quot", i), q, vecs[i].exp_q);
      chk($sformatf("vec%0d_rem", i),  r, vecs[i].exp_r);
    end

    // One-cycle pulse: the cycle after DONE is quiet and idle.
    @(posedge clk); #1; div_start = 0;
    @(negedge clk);
    chk("pulse_width", 32'(res_valid), 32'd0);
    chk("idle_after_done", 32'(div_stall), 32'd0);

    // Start together with flush is not accepted.
    @(posedge clk); #1;
    div_start = 1; flush = 1; div_signed = 0; dividend = 32'd8; divisor = 32'd2;
    @(negedge clk);
    chk("flush_start_stall", 32'(div_stall), 32'd0);
    @(posedge clk); #1; div_start = 0; flush = 0;
    pulses = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (res_valid || div_stall) pulses++;
    end
    chk("flush_start_ignored", 32'(pulses), 32'd0);

    // Flush at T+10, then a new divide at T+11.
    @(posedge clk); #1;
    div_start = 1; div_signed = 0; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1; div_start = 0;
    end
    @(posedge clk); #1; flush = 1;
    @(negedge clk);
    chk("flush_stall", 32'(div_stall), 32'd0);
    run_div("after_flush", 32'd9, 32'd3, 1'b0, q, r);
    chk("after_flush_quot", q, 32'd3);
    chk("after_flush_rem",  r, 32'd0);

    // Reset at T+20 mid-CALC.
    @(posedge clk); #1;
    div_start = 1; div_signed = 0; dividend = 32'd77; divisor = 32'd5;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1; div_start = 0;
    end
    @(posedge clk); #1; reset = 1; flush = 1;
    @(negedge clk);
    chk("midrst_stall", 32'(div_stall), 32'd0);
    @(posedge clk); #1; reset = 0; flush = 0;
    @(negedge clk);
    chk("midrst_idle",  32'(div_stall), 32'd0);
    chk("midrst_quot",  quotient,  32'd0);
    chk("midrst_rem",   remainder, 32'd0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    chk("midrst_no_valid", 32'(pulses), 32'd0);

    // Back-to-back divides.
    run_div("b2b_a", 32'd10, 32'd3, 1'b0, q, r);
    first_valid = last_valid_cyc;
    chk("b2b_a_quot", q, 32'd3);
    chk("b2b_a_rem",  r, 32'd1);
    run_div("b2b_b", 32'd20, 32'd6, 1'b0, q, r);
    chk("b2b_b_quot", q, 32'd3);
    chk("b2b_b_rem",  r, 32'd2);
    chk("b2b_spacing", 32'(last_valid_cyc - first_valid), 32'd34);

    // Randomized divides against the reference.
    for (int i = 0; i < 30; i++) begin
      int mode;
      s    = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      a    = (mode == 9) ? 32'h8000_0000 : 32'($urandom);
      if (mode == 0)      b = 32'd0;
      else if (mode <= 3) b = 32'($urandom_range(1, 15));
      else if (mode == 4) b = 32'hFFFF_FFFF;
      else                b = 32'($urandom) >> $urandom_range(0, 31);
      if (mode == 3) b = 32'(32'd0 - b);
      model(a, b, s, eq, er);
      run_div($sformatf("rnd%0d", i), a, b, s, q, r);
      chk($sformatf("rnd%0d_quot(%h/%h s=%0d)", i, a, b, s), q, eq);
      chk($sformatf("rnd%0d_rem(%h/%h s=%0d)", i, a, b, s),  r, er);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
